bs_pipe_shifter: RTL
====================

// Module: bs_pipe_shifter
// --------------------------------------------------------------------------
// PURPOSE
//   Parametrised, pipelined barrel shifter. Successor to the fixed 4-bit
//   combinational rotate-right shifter.
//   Generalised to WIDTH bits, with four shift/rotate modes per transaction.
//   Uses one register stage per shift-amount bit and valid/ready flow
//   control on both sides.
//   Sits in datapaths that need a shifter at full clock rate with backpressure.
// --------------------------------------------------------------------------
// PARAMETERS
//   WIDTH   32               data width; power of two, >= 4
//   SHW     $clog2(WIDTH)    shift-amount width = pipeline depth (derived, do not override)
// --------------------------------------------------------------------------
// PORTS
//   i_clk      in   1       clock, rising edge
//   i_rst      in   1       synchronous reset, active-high
//   i_valid    in   1       input transaction valid
//   o_ready    out  1       shifter can accept input this cycle
//   i_A        in   WIDTH   operand
//   i_k        in   SHW     shift amount, 0..WIDTH-1
//   i_mode     in   2       00 ROR, 01 ROL, 10 SRL (logical right), 11 SRA (arith right)
//   o_valid    out  1       result valid
//   i_ready    in   1       downstream accepts result
//   o_Y        out  WIDTH   result
// --------------------------------------------------------------------------
// BEHAVIOUR
//   - Reset: i_rst sampled high at a rising edge clears every stage valid bit.
//     After that edge, o_valid=0 and o_Y=0. Data/mode/amount regs clear to 0.
//   - Pipeline: SHW stages. Stage s (0..SHW-1) applies a shift of 2^s when k[s]=1,
//     otherwise passes data through. Each stage registers data, remaining k bits,
//     mode and a valid bit.
//   - Latency: a transaction accepted at edge N appears on o_valid/o_Y after edge
//     N+SHW-1, i.e. SHW register stages, when there are no stalls.
//   - Throughput: 1 transaction/cycle while i_ready=1.
//   - Accept: input transfers when i_valid && o_ready at a rising edge.
//     Output transfers when o_valid && i_ready.
//   - Stall: en = !o_valid || i_ready. All stages advance only when en=1.
//     When en=0 every stage holds.
//     o_ready = en. This is a combinational path from i_ready to o_ready; it is
//     the only comb in->out path.
//   - Bubbles: while en=1, an empty stage takes a bubble from upstream.
//     Bubbles are not compressed during a stall.
//   - Modes:
//       ROR  Y = (A >> k) | (A << (WIDTH-k))
//       ROL  Y = (A << k) | (A >> (WIDTH-k))
//       SRL  zero-fill from the MSB side
//       SRA  fill with A[WIDTH-1], the sign captured at accept and carried
//            through the pipeline
//   - k=0: Y=A in every mode. k=WIDTH-1 is the maximum; there is no overflow
//     case because i_k is SHW bits wide.
//   - Mode and amount are captured per transaction. Changing i_mode or i_k every
//     cycle must not corrupt transactions already in flight.
//   - Inputs are ignored when i_valid=0 or o_ready=0. No output is produced for
//     an input that was not accepted.
//   - Reset mid-operation: all in-flight transactions are discarded.
//     The first o_valid after reset belongs to the first transaction accepted
//     after reset.
//   - i_valid/i_A/i_k/i_mode are not required to stay stable while o_ready=0.
//     The upstream holds them per the normal handshake.
//   - Order is preserved. There is no loss or duplication under any i_ready pattern.
// --------------------------------------------------------------------------
// TESTING   (WIDTH=8, SHW=3 unless noted)
//   1 A=0x96, k=3, i_ready=1, single-cycle i_valid, each mode:
//     ROR->0xD2, ROL->0xB4, SRL->0x12, SRA->0xF2.
//     o_valid pulses for 1 cycle, 3 edges after accept.
//   2 A=0x5A, k=0 in all 4 modes -> 0x5A.
//     A=0x81, k=7: ROR->0x03, ROL->0xC0, SRL->0x01, SRA->0xFF.
//   3 Back-to-back stream of 8 transactions: A=i, k=i%8, mode=i%4, i_ready=1.
//     Results arrive on 8 consecutive cycles, in order, matching a reference model.
//   4 Same stream with i_ready=0 for 2 cycles once the first result is valid:
//     o_Y/o_valid hold, o_ready=0 during the stall.
//     All 8 results delivered exactly once, in order.
//   5 Assert i_rst for 1 cycle with 2 transactions in flight:
//     o_valid=0 after that edge, o_Y=0, neither transaction appears.
//     The next transaction is accepted and returns normally.
//   6 Random: 1000 transactions at WIDTH=32 with random i_valid/i_ready
//     -> scoreboard matches, no mismatch, drop or duplicate.
// --------------------------------------------------------------------------

Source files
------------

// File: rtl/bs_pipe_shifter.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, four
// rotate/shift modes, valid/ready flow control with a global stall enable.
module bs_pipe_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_A,
    input  logic [SHW-1:0]   i_k,
    input  logic [1:0]       i_mode,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_Y
);

    localparam logic [1:0] MODE_ROR = 2'b00;
    localparam logic [1:0] MODE_ROL = 2'b01;
    localparam logic [1:0] MODE_SRL = 2'b10;

    logic en;

    // Shift d by a fixed power-of-two amount; SRA fills with the sign captured at accept.
    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       mode,
                                                  input logic             sign,
                                                  input int               amt);
        logic [WIDTH-1:0] fill;
        fill = sign ? ~({WIDTH{1'b1}} >> amt) : '0;
        case (mode)
            MODE_ROR: shift_by = (d >> amt) | (d << (WIDTH - amt));
            MODE_ROL: shift_by = (d << amt) | (d >> (WIDTH - amt));
            MODE_SRL: shift_by = d >> amt;
            default:  shift_by = (d >> amt) | fill;
        endcase
    endfunction

    // Whole pipeline advances together; a full output with no taker freezes everything.
    assign en      = !o_valid || i_ready;
    assign o_ready = en;

    for (genvar s = 0; s < SHW; s++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic [SHW-1:0]   k_in;
        logic [1:0]       m_in;
        logic             sign_in;
        logic             vld_in;
        logic [WIDTH-1:0] shifted;

        logic [WIDTH-1:0] data_p;
        logic [SHW-1:0]   k_p;
        logic [1:0]       mode_p;
        logic             sign_p;
        logic             vld_p;

        if (s == 0) begin : g_head
            assign d_in    = i_A;
            assign k_in    = i_k;
            assign m_in    = i_mode;
            assign sign_in = i_A[WIDTH-1];
            assign vld_in  = i_valid;
        end else begin : g_link
            assign d_in    = g_stage[s-1].data_p;
            assign k_in    = g_stage[s-1].k_p;
            assign m_in    = g_stage[s-1].mode_p;
            assign sign_in = g_stage[s-1].sign_p;
            assign vld_in  = g_stage[s-1].vld_p;
        end

        assign shifted = k_in[s] ? shift_by(d_in, m_in, sign_in, 2 ** s) : d_in;

        // Stage s boundary: register the partially shifted word and its context.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                vld_p  <= 1'b0;
                data_p <= '0;
                k_p    <= '0;
                mode_p <= '0;
                sign_p <= 1'b0;
            end else if (en) begin
                vld_p  <= vld_in;
                data_p <= shifted;
                k_p    <= k_in;
                mode_p <= m_in;
                sign_p <= sign_in;
            end
        end

        // Already-consumed amount bits and the last stage's context have no reader.
        logic unused_ctx;
        assign unused_ctx = ^{k_p, mode_p, sign_p};
    end

    assign o_valid = g_stage[SHW-1].vld_p;
    assign o_Y     = g_stage[SHW-1].data_p;

endmodule
